ripple_cnt_extender: RTL and testbench

- Downstream consumer of the 3-bit asynchronous ripple counter.
- Brings the ripple output into the system clock domain through a 2-flop synchronizer, then filters out ripple-settling glitches with a stability filter.
- Tracks count advances modulo 2^CNT_W and extends them into a wide EXT_W-bit event count, with wrap, skip-error and overflow reporting.
- Feeds status and accumulated counts to register/readout logic.

---
 rtl/ripple_ext_pkg.sv | 28 ++
 rtl/ripple_sync_filter.sv | 57 +++++
 rtl/ripple_cnt_extender.sv | 109 ++++++++++
 tb/tb_ripple_cnt_extender.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_ext_pkg.sv
// Shared types, default parameters and modular arithmetic helper for the
// ripple counter extender.
package ripple_ext_pkg;

    typedef enum logic {
        ARM   = 1'b0,
        TRACK = 1'b1
    } ext_state_e;

    localparam int unsigned DEF_CNT_W     = 3;
    localparam int unsigned DEF_EXT_W     = 16;
    localparam int unsigned DEF_STABLE_N  = 2;
    localparam int unsigned DEF_MAX_DELTA = 2;

    // Widest counter the difference helper supports.
    localparam int unsigned DIFF_W = 16;

    function automatic logic [DIFF_W-1:0] mod_diff(
        input logic [DIFF_W-1:0] a,
        input logic [DIFF_W-1:0] b,
        input int unsigned       w
    );
        logic [DIFF_W-1:0] mask;
        mask = (DIFF_W'(1) << w) - DIFF_W'(1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/ripple_sync_filter.sv
// Two-flop synchronizer for the ripple counter bus followed by a stability
// filter that accepts a value only after STABLE_N identical samples.
module ripple_sync_filter
    import ripple_ext_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned STABLE_N = DEF_STABLE_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] ripple_q,
    output logic [CNT_W-1:0] cand,
    output logic             acc_valid
);

    localparam int unsigned     SW       = $clog2(STABLE_N);
    localparam logic [SW-1:0]   STAB_MAX = SW'(STABLE_N - 1);

    logic [CNT_W-1:0] s1_q, s2_q, s2_prev_q;
    logic [CNT_W-1:0] cand_q, cand_d;
    logic             cand_vld_q;
    logic [SW-1:0]    stab_cnt_q, stab_cnt_d;

    // Acceptance keys off the next stab_cnt so the value is handed over on
    // the same cycle the STABLE_N-th matching sample is seen.
    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (s2_q != s2_prev_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + SW'(1);
        end
        acc_valid = (stab_cnt_d == STAB_MAX) && (!cand_vld_q || (s2_q != cand_q));
        cand_d    = acc_valid ? s2_q : cand_q;
    end

    assign cand = cand_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s2_prev_q  <= '0;
            stab_cnt_q <= '0;
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
        end else begin
            s1_q       <= ripple_q;
            s2_q       <= s1_q;
            s2_prev_q  <= s2_q;
            stab_cnt_q <= stab_cnt_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_q | acc_valid;
        end
    end

endmodule

// File: rtl/ripple_cnt_extender.sv
// Extends a filtered ripple counter value into a wide event count with
// wrap, skip-error and overflow reporting.
module ripple_cnt_extender
    import ripple_ext_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned EXT_W     = DEF_EXT_W,
    parameter int unsigned STABLE_N  = DEF_STABLE_N,
    parameter int unsigned MAX_DELTA = DEF_MAX_DELTA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] ripple_q,
    input  logic             enable,
    input  logic             clr,
    output logic [EXT_W-1:0] ext_count,
    output logic             upd,
    output logic [CNT_W-1:0] delta,
    output logic             wrap,
    output logic             skip_err,
    output logic             ovf,
    output logic             locked
);

    localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DELTA);

    logic [CNT_W-1:0] cand;
    logic             acc_valid;

    ripple_sync_filter #(
        .CNT_W   (CNT_W),
        .STABLE_N(STABLE_N)
    ) u_filter (
        .clk      (clk),
        .rst      (rst),
        .ripple_q (ripple_q),
        .cand     (cand),
        .acc_valid(acc_valid)
    );

    ext_state_e       state_q;
    logic [CNT_W-1:0] base_q;
    logic [EXT_W-1:0] ext_count_q;
    logic [CNT_W-1:0] delta_q;
    logic             upd_q, wrap_q, skip_err_q, ovf_q, locked_q;

    logic [CNT_W-1:0] step_d;
    logic [EXT_W:0]   sum_d;

    always_comb begin
        step_d = CNT_W'(mod_diff(DIFF_W'(cand), DIFF_W'(base_q), CNT_W));
        sum_d  = {1'b0, ext_count_q} + (EXT_W + 1)'(step_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ARM;
            base_q      <= '0;
            ext_count_q <= '0;
            delta_q     <= '0;
            upd_q       <= 1'b0;
            wrap_q      <= 1'b0;
            skip_err_q  <= 1'b0;
            ovf_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            upd_q  <= 1'b0;
            wrap_q <= 1'b0;
            if (clr) begin
                ext_count_q <= '0;
                delta_q     <= '0;
                skip_err_q  <= 1'b0;
                ovf_q       <= 1'b0;
                locked_q    <= 1'b0;
                state_q     <= ARM;
            end else if (acc_valid) begin
                case (state_q)
                    ARM: begin
                        base_q   <= cand;
                        locked_q <= 1'b1;
                        state_q  <= TRACK;
                    end
                    TRACK: begin
                        base_q <= cand;
                        if (step_d > MAX_D) begin
                            skip_err_q <= 1'b1;
                        end else if ((step_d != '0) && enable) begin
                            ext_count_q <= sum_d[EXT_W-1:0];
                            if (sum_d[EXT_W]) ovf_q <= 1'b1;
                            upd_q   <= 1'b1;
                            delta_q <= step_d;
                            wrap_q  <= (cand < base_q);
                        end
                    end
                    default: state_q <= ARM;
                endcase
            end
        end
    end

    assign ext_count = ext_count_q;
    assign upd       = upd_q;
    assign delta     = delta_q;
    assign wrap      = wrap_q;
    assign skip_err  = skip_err_q;
    assign ovf       = ovf_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_ripple_cnt_extender.sv
// Directed bench for ripple_cnt_extender: a default instance plus an EXT_W=4
// instance used for overflow and clear-versus-accept timing.
module tb_ripple_cnt_extender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, clr;
    logic [2:0]  ripple_q;
    logic [15:0] ext_count;
    logic        upd, wrap, skip_err, ovf, locked;
    logic [2:0]  delta;

    logic        en4, clr4;
    logic [2:0]  rip4;
    logic [3:0]  ext4;
    logic        upd4, wrap4, skip4, ovf4, locked4;
    logic [2:0]  delta4;

    int n_cmp = 0;
    int n_err = 0;
    int upd_cnt = 0;
    int wrap_cnt = 0;
    int upd4_cnt = 0;
    logic [2:0] last_delta = 3'd0;

    ripple_cnt_extender u_dut (
        .clk(clk), .rst(rst), .ripple_q(ripple_q), .enable(enable), .clr(clr),
        .ext_count(ext_count), .upd(upd), .delta(delta), .wrap(wrap),
        .skip_err(skip_err), .ovf(ovf), .locked(locked)
    );

    ripple_cnt_extender #(.EXT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .ripple_q(rip4), .enable(en4), .clr(clr4),
        .ext_count(ext4), .upd(upd4), .delta(delta4), .wrap(wrap4),
        .skip_err(skip4), .ovf(ovf4), .locked(locked4)
    );

    always @(negedge clk) begin
        if (upd) begin
            upd_cnt = upd_cnt + 1;
            last_delta = delta;
            if (wrap) wrap_cnt = wrap_cnt + 1;
        end
        if (upd4) upd4_cnt = upd4_cnt + 1;
    end

    task automatic drive(input logic [2:0] v, input int n);
        ripple_q = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [2:0] v, input int n);
        rip4 = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ext_count !== 16'd0) begin n_err++; $display("FAIL rst_ext: got %0d want 0", ext_count); end
        n_cmp++; if (upd !== 1'b0)        begin n_err++; $display("FAIL rst_upd: got %b want 0", upd); end
        n_cmp++; if (delta !== 3'd0)      begin n_err++; $display("FAIL rst_delta: got %0d want 0", delta); end
        n_cmp++; if (wrap !== 1'b0)       begin n_err++; $display("FAIL rst_wrap: got %b want 0", wrap); end
        n_cmp++; if (skip_err !== 1'b0)   begin n_err++; $display("FAIL rst_skip: got %b want 0", skip_err); end
        n_cmp++; if (ovf !== 1'b0)        begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_cmp++; if (locked !== 1'b0)     begin n_err++; $display("FAIL rst_locked: got %b want 0", locked); end
        rst = 1'b1;
        upd_cnt = 0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (locked !== 1'b1)     begin n_err++; $display("FAIL lock_after4: got %b want 1", locked); end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (ext_count !== 16'd0) begin n_err++; $display("FAIL lock_ext: got %0d want 0", ext_count); end
        n_cmp++; if (upd_cnt != 0)        begin n_err++; $display("FAIL lock_no_upd: got %0d want 0", upd_cnt); end
    endtask

    task automatic test_count_wrap;
        upd_cnt = 0;
        wrap_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            drive(3'(i), 6);
            n_cmp++;
            if (ext_count !== 16'(i)) begin n_err++; $display("FAIL step_ext[%0d]: got %0d want %0d", i, ext_count, i); end
        end
        n_cmp++; if (upd_cnt != 8)        begin n_err++; $display("FAIL step_upd_cnt: got %0d want 8", upd_cnt); end
        n_cmp++; if (last_delta !== 3'd1) begin n_err++; $display("FAIL step_delta: got %0d want 1", last_delta); end
        n_cmp++; if (wrap_cnt != 1)       begin n_err++; $display("FAIL step_wrap_cnt: got %0d want 1", wrap_cnt); end
        n_cmp++; if (skip_err !== 1'b0)   begin n_err++; $display("FAIL step_skip: got %b want 0", skip_err); end
    endtask

    task automatic test_glitch;
        drive(3'd1, 6);
        drive(3'd2, 6);
        drive(3'd3, 6);
        n_cmp++; if (ext_count !== 16'd11) begin n_err++; $display("FAIL glitch_pre_ext: got %0d want 11", ext_count); end
        upd_cnt = 0;
        drive(3'd2, 1);
        drive(3'd0, 1);
        drive(3'd4, 6);
        n_cmp++; if (upd_cnt != 1)         begin n_err++; $display("FAIL glitch_upd_cnt: got %0d want 1", upd_cnt); end
        n_cmp++; if (last_delta !== 3'd1)  begin n_err++; $display("FAIL glitch_delta: got %0d want 1", last_delta); end
        n_cmp++; if (ext_count !== 16'd12) begin n_err++; $display("FAIL glitch_ext: got %0d want 12", ext_count); end
        n_cmp++; if (skip_err !== 1'b0)    begin n_err++; $display("FAIL glitch_skip: got %b want 0", skip_err); end
    endtask

    task automatic test_skip;
        pulse_clr;
        n_cmp++; if (ext_count !== 16'd0) begin n_err++; $display("FAIL clr_ext: got %0d want 0", ext_count); end
        n_cmp++; if (delta !== 3'd0)      begin n_err++; $display("FAIL clr_delta: got %0d want 0", delta); end
        n_cmp++; if (locked !== 1'b0)     begin n_err++; $display("FAIL clr_locked: got %b want 0", locked); end
        drive(3'd1, 6);
        n_cmp++; if (locked !== 1'b1)     begin n_err++; $display("FAIL skip_base_lock: got %b want 1", locked); end
        upd_cnt = 0;
        drive(3'd5, 6);
        n_cmp++; if (skip_err !== 1'b1)   begin n_err++; $display("FAIL skip_flag: got %b want 1", skip_err); end
        n_cmp++; if (ext_count !== 16'd0) begin n_err++; $display("FAIL skip_ext: got %0d want 0", ext_count); end
        n_cmp++; if (upd_cnt != 0)        begin n_err++; $display("FAIL skip_no_upd: got %0d want 0", upd_cnt); end
        drive(3'd6, 6);
        n_cmp++; if (upd_cnt != 1)        begin n_err++; $display("FAIL resync_upd_cnt: got %0d want 1", upd_cnt); end
        n_cmp++; if (last_delta !== 3'd1) begin n_err++; $display("FAIL resync_delta: got %0d want 1", last_delta); end
        n_cmp++; if (ext_count !== 16'd1) begin n_err++; $display("FAIL resync_ext: got %0d want 1", ext_count); end
        n_cmp++; if (skip_err !== 1'b1)   begin n_err++; $display("FAIL skip_sticky: got %b want 1", skip_err); end
    endtask

    task automatic test_enable;
        pulse_clr;
        n_cmp++; if (skip_err !== 1'b0)   begin n_err++; $display("FAIL clr_skip: got %b want 0", skip_err); end
        drive(3'd2, 6);
        upd_cnt = 0;
        enable = 1'b0;
        drive(3'd3, 6);
        drive(3'd4, 6);
        n_cmp++; if (upd_cnt != 0)        begin n_err++; $display("FAIL dis_no_upd: got %0d want 0", upd_cnt); end
        n_cmp++; if (ext_count !== 16'd0) begin n_err++; $display("FAIL dis_ext: got %0d want 0", ext_count); end
        enable = 1'b1;
        drive(3'd5, 6);
        n_cmp++; if (upd_cnt != 1)        begin n_err++; $display("FAIL reen_upd_cnt: got %0d want 1", upd_cnt); end
        n_cmp++; if (last_delta !== 3'd1) begin n_err++; $display("FAIL reen_delta: got %0d want 1", last_delta); end
        n_cmp++; if (ext_count !== 16'd1) begin n_err++; $display("FAIL reen_ext: got %0d want 1", ext_count); end
    endtask

    task automatic test_async_reset;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (ext_count !== 16'd0) begin n_err++; $display("FAIL arst_ext: got %0d want 0", ext_count); end
        n_cmp++; if (delta !== 3'd0)      begin n_err++; $display("FAIL arst_delta: got %0d want 0", delta); end
        n_cmp++; if (locked !== 1'b0)     begin n_err++; $display("FAIL arst_locked: got %b want 0", locked); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_overflow;
        upd4_cnt = 0;
        for (int i = 1; i <= 15; i++) drive4(3'(i), 6);
        n_cmp++; if (ext4 !== 4'd15)  begin n_err++; $display("FAIL ovf_pre_ext: got %0d want 15", ext4); end
        n_cmp++; if (ovf4 !== 1'b0)   begin n_err++; $display("FAIL ovf_pre_flag: got %b want 0", ovf4); end
        n_cmp++; if (upd4_cnt != 15)  begin n_err++; $display("FAIL ovf_pre_upd_cnt: got %0d want 15", upd4_cnt); end
        rip4 = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (upd4 !== 1'b0)   begin n_err++; $display("FAIL lat_early: got %b want 0", upd4); end
        @(posedge clk); #1;
        n_cmp++; if (upd4 !== 1'b1)   begin n_err++; $display("FAIL lat_upd: got %b want 1", upd4); end
        n_cmp++; if (ext4 !== 4'd0)   begin n_err++; $display("FAIL ovf_ext: got %0d want 0", ext4); end
        n_cmp++; if (ovf4 !== 1'b1)   begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf4); end
        n_cmp++; if (delta4 !== 3'd1) begin n_err++; $display("FAIL ovf_delta: got %0d want 1", delta4); end
        n_cmp++; if (wrap4 !== 1'b1)  begin n_err++; $display("FAIL ovf_wrap: got %b want 1", wrap4); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (upd4 !== 1'b0)   begin n_err++; $display("FAIL upd_one_cycle: got %b want 0", upd4); end
        n_cmp++; if (ovf4 !== 1'b1)   begin n_err++; $display("FAIL ovf_sticky: got %b want 1", ovf4); end
    endtask

    task automatic test_clr_race;
        rip4 = 3'd1;
        repeat (3) @(posedge clk);
        #1;
        clr4 = 1'b1;
        @(posedge clk); #1;
        clr4 = 1'b0;
        n_cmp++; if (ext4 !== 4'd0)    begin n_err++; $display("FAIL race_ext: got %0d want 0", ext4); end
        n_cmp++; if (ovf4 !== 1'b0)    begin n_err++; $display("FAIL race_ovf: got %b want 0", ovf4); end
        n_cmp++; if (locked4 !== 1'b0) begin n_err++; $display("FAIL race_locked: got %b want 0", locked4); end
        n_cmp++; if (upd4 !== 1'b0)    begin n_err++; $display("FAIL race_upd: got %b want 0", upd4); end
        n_cmp++; if (delta4 !== 3'd0)  begin n_err++; $display("FAIL race_delta: got %0d want 0", delta4); end
        n_cmp++; if (wrap4 !== 1'b0)   begin n_err++; $display("FAIL race_wrap: got %b want 0", wrap4); end
        n_cmp++; if (skip4 !== 1'b0)   begin n_err++; $display("FAIL race_skip: got %b want 0", skip4); end
        upd4_cnt = 0;
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (locked4 !== 1'b0) begin n_err++; $display("FAIL race_still_arm: got %b want 0", locked4); end
        drive4(3'd2, 6);
        n_cmp++; if (locked4 !== 1'b1) begin n_err++; $display("FAIL rebase_locked: got %b want 1", locked4); end
        n_cmp++; if (ext4 !== 4'd0)    begin n_err++; $display("FAIL rebase_ext: got %0d want 0", ext4); end
        n_cmp++; if (upd4_cnt != 0)    begin n_err++; $display("FAIL rebase_no_upd: got %0d want 0", upd4_cnt); end
    endtask

    initial begin
        rst = 1'b0;
        ripple_q = 3'd0;
        enable = 1'b1;
        clr = 1'b0;
        rip4 = 3'd0;
        en4 = 1'b1;
        clr4 = 1'b0;
        test_reset;
        test_count_wrap;
        test_glitch;
        test_skip;
        test_enable;
        test_async_reset;
        test_overflow;
        test_clr_race;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
